// File: rtl/adder64_seq.sv
// adder64_seq: multi-cycle 64-bit adder that adds CHUNK bits per clock.
// A start in IDLE captures the operands. RUN walks the chunks from LSB to MSB
// while it ripples the carry. DONE presents the result with a one-cycle pulse.
module adder64_seq #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
  output logic        cout,
  output logic        overflow
);

  localparam int NCHUNK = 64 / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [63:0]     a_reg;
  logic [63:0]     b_reg;
  logic [KW-1:0]   k;
  logic            carry;
  logic [6:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]  chunk_add;
  logic            last;

  // Select the current chunk and add it together with the running carry
  always_comb begin
    base      = 7'(k) * 7'(CHUNK);
    a_chunk   = a_reg[base +: CHUNK];
    b_chunk   = b_reg[base +: CHUNK];
    chunk_add = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    last      = (k == KLAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start only counts in IDLE, and DONE lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, then ripple one chunk per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      k        <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
          end
        end
        RUN: begin
          sum[base +: CHUNK] <= chunk_add[CHUNK-1:0];
          carry              <= chunk_add[CHUNK];
          k                  <= k + KW'(1);
          if (last) begin
            cout     <= chunk_add[CHUNK];
            overflow <= (a_reg[63] == b_reg[63]) && (chunk_add[CHUNK-1] != a_reg[63]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_adder64_seq.sv
// tb_adder64_seq: directed vector table, multi-cycle corner sequences and
// random operands checked against a plain 65-bit arithmetic model.
module tb_adder64_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[5];

  adder64_seq #(.CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, overflow from the operand and result signs
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] t;
    t  = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
    s  = t[63:0];
    co = t[64];
    ov = (ma[63] == mb[63]) && (t[63] != ma[63]);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands at a negedge. Return 1 time unit after the accepting edge N.
  task automatic applyStimulus(input logic [63:0] sa, input logic [63:0] sb, input logic sc);
    @(negedge clk);
    start = 1'b1; a = sa; b = sb; cin = sc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen, with a bound
  task automatic waitDone(input int already, output int lat);
    lat = already;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [63:0] sa, input logic [63:0] sb,
                       input logic sc, input logic [63:0] es, input logic eco, input logic eov);
    int lat;
    applyStimulus(sa, sb, sc);
    checkOutput({name, " busy"}, 64'(busy), 64'd1);
    waitDone(0, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'd8);
    checkOutput({name, " sum"}, sum, es);
    checkOutput({name, " cout"}, 64'(cout), 64'(eco));
    checkOutput({name, " overflow"}, 64'(overflow), 64'(eov));
    @(posedge clk);
    #1;
    checkOutput({name, " done_drop"}, 64'(done), 64'd0);
    checkOutput({name, " sum_hold"}, sum, es);
  endtask

  initial begin
    logic [63:0] ra, rb, es;
    logic        rc, eco, eov;
    int          lat;
    int          done_seen;

    vecs[0] = '{64'd10, 64'd3, 1'b0, 64'd13, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset sum", sum, 64'd0);
    checkOutput("reset cout", 64'(cout), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++)
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].s, vecs[i].co, vecs[i].ov);

    // Abort at edge N+4: outputs clear at once, no done pulse follows
    ra = {$urandom, $urandom} | 64'h1;
    rb = {$urandom, $urandom};
    applyStimulus(ra, rb, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort sum", sum, 64'd0);
    checkOutput("abort cout", 64'(cout), 64'd0);
    checkOutput("abort overflow", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort no_done", 64'(done_seen), 64'd0);
    model(ra, rb, 1'b1, es, eco, eov);
    runOp("after_abort", ra, rb, 1'b1, es, eco, eov);

    // Restart during RUN and DONE is ignored: one pulse, 5+6 only
    applyStimulus(64'd5, 64'd6, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 64'd100; b = 64'd100;
    waitDone(2, lat);
    checkOutput("restart latency", 64'(lat), 64'd8);
    checkOutput("restart sum", sum, 64'd11);
    @(posedge clk);
    #1;
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("restart single_op", 64'(done_seen), 64'd0);
    checkOutput("restart sum_hold", sum, 64'd11);

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, es, eco, eov);
      runOp($sformatf("rand%0d", i), ra, rb, rc, es, eco, eov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
